midi_uart_tx: RTL
=================

MIDI_UART_TX -- requirements
Module: midi_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 24576000, meaning the CLK_AUDIO frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, meaning the MIDI bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning the byte FIFO capacity; it SHALL be a power of two, 2..256.
REQ-004 One clock; reset is synchronous and active-high: port CLK_AUDIO, input, 1 bit, the sole clock.
REQ-005 Port reset, input, 1 bit, synchronous active-high reset.
REQ-006 Port in_data, input, 8 bits, MIDI byte from the host core.
REQ-007 Port in_valid, input, 1 bit, in_data is valid this cycle.
REQ-008 Port in_ready, output, 1 bit, the FIFO can accept a byte this cycle.
REQ-009 Port midi_tx, output, 1 bit, serial MIDI line that drives the MT32-pi TX pin; idles high.
REQ-010 Port busy, output, 1 bit, the FIFO is non-empty or a frame is in flight.
REQ-011 Port fifo_level, output, clog2(FIFO_DEPTH)+1 bits, current FIFO occupancy.

Function
REQ-012 A byte SHALL be pushed on any rising CLK_AUDIO edge with in_valid & in_ready.
REQ-013 in_ready SHALL equal (fifo_level != FIFO_DEPTH); pushes are blocked while full, even in a cycle with a pop.
REQ-014 The FIFO SHALL be first-in first-out. Read and write pointers SHALL wrap modulo FIFO_DEPTH with no loss or duplication.
REQ-015 A simultaneous push and pop when the FIFO is neither empty nor full SHALL leave fifo_level unchanged.
REQ-016 The bit period SHALL be DIV = round(CLK_HZ/BAUD) cycles (786 at the defaults), counted by a down-counter reloaded at each bit boundary.
REQ-017 The state machine SHALL have four states: IDLE, START, DATA, STOP.
REQ-018 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte into a shift register and enter START. midi_tx SHALL go low on the next cycle.
REQ-019 START SHALL hold midi_tx=0 for DIV cycles, then enter DATA.
REQ-020 DATA SHALL send 8 bits LSB-first, each for DIV cycles, using a 3-bit bit index, then enter STOP.
REQ-021 STOP SHALL hold midi_tx=1 for DIV cycles, then return to IDLE. A frame is 10*DIV cycles (8N1).
REQ-022 Back-to-back bytes: a pop in the IDLE cycle that follows STOP SHALL give one extra idle-high cycle between frames, no more.
REQ-023 Bytes pushed while a frame is in flight SHALL NOT alter that frame.
REQ-024 busy SHALL be high from the cycle after the first push until the cycle after STOP completes with the FIFO empty.
REQ-025 midi_tx SHALL be registered and glitch-free, with no combinational path from in_* to midi_tx.

Reset
REQ-026 While reset is high: midi_tx=1, in_ready=0, busy=0, fifo_level=0, FSM=IDLE, pointers and counters=0.
REQ-027 in_ready SHALL rise on the first cycle after reset deasserts.
REQ-028 Reset during a frame SHALL abort it: midi_tx=1 on the cycle after reset is sampled, and FIFO contents are discarded.

Structure
REQ-029 Package mimic_midi_pkg SHALL hold the state enum (IDLE/START/DATA/STOP), MIDI_BAUD=31250, and a function computing DIV.
REQ-030 The FIFO SHALL be one sub-module, midi_fifo (synchronous, single clock, parameterised depth/width, level output). The UART FSM SHALL stay in midi_uart_tx.

Verification
REQ-031 Bench: CLK_HZ=1000, BAUD=100 (DIV=10). Push 0x90 -> midi_tx low for cycles 1-10 after the pop, then bits 0,0,0,0,1,0,0,1 in 10-cycle slots, then high for 10 cycles; busy then falls.
REQ-032 Bench: push 0x90,0x3C,0x7F back-to-back -> three frames spaced 101 cycles, byte order preserved, fifo_level peaks at 2.
REQ-033 Bench: FIFO_DEPTH=4, hold in_valid for 6 bytes with TX stalled in a frame -> in_ready low once level=4, the 5th byte is held until a pop, and all 6 bytes emerge in order.
REQ-034 Bench: 20 pushes interleaved with pops through FIFO_DEPTH=16 (pointer wrap) -> output sequence matches the input exactly.
REQ-035 Bench: assert reset in DATA bit 4 of 0xAA with 3 bytes queued -> midi_tx=1 the next cycle, fifo_level=0, and no further frames follow.
REQ-036 Bench: push in the same cycle STOP ends with the FIFO empty -> the byte is accepted and its start bit begins within 2 cycles; busy never drops.

Source files
------------

// File: rtl/mimic_midi_pkg.sv
// Purpose : shared state encoding, MIDI constants and the bit-period helper.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: uart_state_e (IDLE/START/DATA/STOP), MIDI_BAUD, calc_div().
package mimic_midi_pkg;

  localparam int MIDI_BAUD = 31250;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Bit period in clock cycles, rounded to nearest: round(clk_hz / baud).
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/midi_fifo.sv
// Purpose : synchronous single-clock FIFO with occupancy output.
// Latency : a pushed word is visible on dout_o the cycle after the push (fall-through read).
// Backpr. : pushes are ignored while full, pops ignored while empty, even if the other side is active.
// Ports   : clk_i/rst_i (sync active-high), push_i/din_i write side, pop_i/dout_o read side,
//           level_o occupancy, full_o/empty_o status flags.
module midi_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: level/pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/midi_uart_tx.sv
// Purpose : buffered 8N1 MIDI serial transmitter (byte FIFO + UART FSM).
// Latency : start bit appears the cycle after the pop; frame = 10 bit periods, +1 idle cycle between frames.
// Backpr. : in_ready drops while the FIFO is full; a held byte is taken once a pop frees a slot.
// Ports   : CLK_AUDIO sole clock, reset sync active-high; in_data/in_valid/in_ready byte input;
//           midi_tx serial line (idle high, registered); busy = queued or in flight; fifo_level occupancy.
module midi_uart_tx
  import mimic_midi_pkg::*;
#(
  parameter int CLK_HZ     = 24576000,
  parameter int BAUD       = MIDI_BAUD,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK_AUDIO,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          midi_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);

  uart_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic             pop;

  // Gated by reset so the host sees no ready while the block is held in reset.
  assign in_ready = ~reset & ~fifo_full;
  assign pop      = (state_q == IDLE) & ~fifo_empty;
  assign busy     = (state_q != IDLE) | ~fifo_empty;
  assign midi_tx  = tx_q;

  midi_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (CLK_AUDIO),
    .rst_i   (reset),
    .push_i  (in_valid & in_ready),
    .din_i   (in_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The frame byte lives in shift_q from the pop onward, so later pushes
  // cannot disturb a frame in flight. cnt_q counts down from DIV-1; each
  // state boundary happens when it reaches zero and reloads it.
  always_ff @(posedge CLK_AUDIO) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            shift_q <= fifo_dout;
            cnt_q   <= DIV_M1;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            cnt_q   <= DIV_M1;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= DIV_M1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
